// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes, arbiter states.
// Used by the ALU, its arbiter and their benches.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_SLL = 4'h5;
  localparam logic [OP_W-1:0] OP_SRL = 4'h6;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// prio names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // single requester wins outright; ties go to prio
  always_comb begin
    gnt = req;
    if (&req) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters.
// One op in flight: accept, execute, return result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  arb_state_t state, state_nx;
  logic       prio;
  logic       owner;
  logic [2:0] lat_cnt;
  logic [1:0] gnt;
  logic       accept;

  rr_arb2 u_rr (
    .req  ({req1_valid, req0_valid}),
    .prio (prio),
    .gnt  (gnt)
  );

  assign accept = (state == IDLE) && (|gnt);

  // next state and handshake outputs; ready is also masked by reset
  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = reset_n & gnt[0];
        req1_ready = reset_n & gnt[1];
        if (|gnt) state_nx = EXEC;
      end
      EXEC: begin
        if (lat_cnt == '0) state_nx = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // grant bookkeeping and the latency counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio    <= 1'b0;
      owner   <= 1'b0;
      lat_cnt <= '0;
    end else if (accept) begin
      prio    <= gnt[0];
      owner   <= gnt[1];
      lat_cnt <= 3'(ALU_LAT);
    end else if (state == EXEC && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // operand registers double as ALU drivers; result captured at lat 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        alu_a  <= gnt[1] ? req1_a  : req0_a;
        alu_b  <= gnt[1] ? req1_b  : req0_b;
        alu_op <= gnt[1] ? req1_op : req0_op;
      end
      if (state == EXEC && lat_cnt == '0)
        rsp_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at ALU_LAT 1 and 4.
// Bench ALU models are delay-matched pipelines.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        r0v, r0r, r1v, r1r;
  logic [15:0] r0a, r0b, r1a, r1b;
  logic [3:0]  r0op, r1op;
  logic        s0v, s0r, s1v, s1r;
  logic [15:0] rdat, aa, ab, ares;
  logic [3:0]  aop;
  logic        bsy;

  logic        q0v, q0r, q1v, q1r;
  logic [15:0] q0a, q0b, q1a, q1b;
  logic [3:0]  q0op, q1op;
  logic        t0v, t0r, t1v, t1r;
  logic [15:0] rdat4, aa4, ab4, ares4;
  logic [3:0]  aop4;
  logic        bsy4;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter u_dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(r0r),
    .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(r1r),
    .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp0_valid(s0v), .rsp0_ready(s0r),
    .rsp1_valid(s1v), .rsp1_ready(s1r),
    .rsp_data(rdat),
    .alu_a(aa), .alu_b(ab), .alu_op(aop),
    .alu_result(ares), .busy(bsy)
  );

  alu_arbiter #(.ALU_LAT(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(q0v), .req0_ready(q0r),
    .req0_a(q0a), .req0_b(q0b), .req0_op(q0op),
    .req1_valid(q1v), .req1_ready(q1r),
    .req1_a(q1a), .req1_b(q1b), .req1_op(q1op),
    .rsp0_valid(t0v), .rsp0_ready(t0r),
    .rsp1_valid(t1v), .rsp1_ready(t1r),
    .rsp_data(rdat4),
    .alu_a(aa4), .alu_b(ab4), .alu_op(aop4),
    .alu_result(ares4), .busy(bsy4)
  );

  function automatic logic [15:0] alu_f(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [3:0]  op
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 16'h0;
    endcase
  endfunction

  logic [15:0] p1;
  logic [15:0] p4 [4];

  always @(posedge clock) p1 <= alu_f(aa, ab, aop);
  assign ares = p1;

  always @(posedge clock) begin
    p4[0] <= alu_f(aa4, ab4, aop4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign ares4 = p4[3];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g[$];
    int gc[$];

    reset_n = 1'b0;
    r0v = 1; r0a = 16'd5; r0b = 16'd3; r0op = OP_ADD;
    r1v = 1; r1a = 16'd7; r1b = 16'd2; r1op = OP_SUB;
    s0r = 1; s1r = 1;
    q0v = 0; q0a = 0; q0b = 0; q0op = 0;
    q1v = 0; q1a = 0; q1b = 0; q1op = 0;
    t0r = 0; t1r = 0;

    nxt();
    check("rst_busy", bsy, 0);
    check("rst_r0r", r0r, 0);
    check("rst_r1r", r1r, 0);
    check("rst_s0v", s0v, 0);
    check("rst_s1v", s1v, 0);
    check("rst_data", rdat, 0);
    check("rst_alu_a", aa, 0);
    check("rst_alu_b", ab, 0);
    check("rst_alu_op", aop, 0);
    check("rst_busy4", bsy4, 0);

    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 40 && g.size() < 3; c++) begin
      check("ct_onehot", r0r & r1r, 0);
      if (r0v && r0r) begin g.push_back(0); gc.push_back(c); end
      if (r1v && r1r) begin g.push_back(1); gc.push_back(c); end
      if (s0v) check("ct_rsp0", rdat, 16'd8);
      if (s1v) check("ct_rsp1", rdat, 16'd5);
      if (g.size() < 3) nxt();
    end
    check("ct_count", g.size(), 3);
    if (g.size() == 3) begin
      check("ct_g0", g[0], 0);
      check("ct_g1", g[1], 1);
      check("ct_g2", g[2], 0);
      check("ct_gap01", gc[1] - gc[0], 4);
      check("ct_gap12", gc[2] - gc[1], 4);
    end
    r0v = 0; r1v = 0;
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
    s0r = 0; s1r = 0;

    nxt(); nxt();
    r0v = 1; r0a = 16'd1; r0b = 16'd0; r0op = OP_ADD;
    #1;
    check("sr_r0r", r0r, 1);
    check("sr_r1r", r1r, 0);
    nxt();
    r0v = 0;
    check("sr_alu_a_t1", aa, 1);
    check("sr_busy", bsy, 1);
    check("sr_s0v_t1", s0v, 0);
    nxt();
    check("sr_alu_a_t2", aa, 1);
    check("sr_s0v_t2", s0v, 0);
    nxt();
    check("sr_s0v_t3", s0v, 1);
    check("sr_data", rdat, 16'd1);
    check("sr_s1v", s1v, 0);
    s0r = 1;
    nxt();
    check("sr_idle", bsy, 0);
    check("sr_s0v_done", s0v, 0);
    s0r = 0;

    r1v = 1; r1a = 16'd0; r1b = 16'd1; r1op = OP_SUB;
    #1;
    check("bp_r1r", r1r, 1);
    nxt();
    r1v = 0; r0v = 1; s0r = 1;
    #1;
    check("bp_r0r_exec", r0r, 0);
    nxt(); nxt();
    for (int i = 0; i < 10; i++) begin
      check("bp_s1v", s1v, 1);
      check("bp_data", rdat, 16'hFFFF);
      check("bp_r0r", r0r, 0);
      check("bp_s0v", s0v, 0);
      nxt();
    end
    r0v = 0;
    nxt();
    r0v = 1;
    #1;
    check("wd_r0r", r0r, 0);
    nxt();
    r0v = 0;
    s1r = 1;
    nxt();
    check("bp_idle", bsy, 0);
    check("bp_s1v_done", s1v, 0);
    s1r = 0; s0r = 0;
    r0v = 1; r1v = 1;
    #1;
    check("wd_prio_r0r", r0r, 1);
    check("wd_prio_r1r", r1r, 0);
    r0v = 0; r1v = 0;
    #1;
    check("wd_nogrant", r0r | r1r, 0);

    nxt();
    r1v = 1; r1a = 16'd3; r1b = 16'd4; r1op = OP_ADD;
    #1;
    check("rm_r1r", r1r, 1);
    nxt();
    r1v = 0;
    check("rm_busy_exec", bsy, 1);
    r0v = 1;
    reset_n = 1'b0;
    #1;
    check("rm_busy", bsy, 0);
    check("rm_r0r", r0r, 0);
    check("rm_r1r0", r1r, 0);
    check("rm_s0v", s0v, 0);
    check("rm_s1v", s1v, 0);
    nxt();
    reset_n = 1'b1;
    r0v = 0;
    for (int i = 0; i < 6; i++) begin
      nxt();
      check("rm_post_s1v", s1v, 0);
      check("rm_post_busy", bsy, 0);
    end
    r1v = 1; r1a = 16'd9; r1b = 16'd4; r1op = OP_SUB;
    #1;
    check("rm_again_r1r", r1r, 1);
    nxt();
    r1v = 0;
    nxt(); nxt();
    check("rm_again_s1v", s1v, 1);
    check("rm_again_data", rdat, 16'd5);
    s1r = 1;
    nxt();
    check("rm_again_idle", bsy, 0);
    s1r = 0;

    q0v = 1; q0a = 16'h1234; q0b = 16'h0101; q0op = OP_XOR;
    #1;
    check("l4_r0r", q0r, 1);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      q0v = 0;
      check("l4_t0v_early", t0v, 0);
      check("l4_busy", bsy4, 1);
    end
    nxt();
    check("l4_t0v", t0v, 1);
    check("l4_data", rdat4, 16'h1335);
    t0r = 1;
    nxt();
    check("l4_idle", bsy4, 0);
    t0r = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares the single `ALU` datapath instance between two clients. It accepts one operation at a time from either requester over a valid/ready handshake, selected round-robin. It drives the ALU operand and opcode inputs for the ALU latency, captures the result, and returns it to the owning requester over a valid/ready response channel. It sits between the ALU and its clients, and is the only block that drives ALU inputs.

## Interface
- `WIDTH`, 16, operand/result width
- `OP_W`, 4, opcode width
- `ALU_LAT`, 1, cycles from operands presented to `alu_result` valid (ALU is registered); legal range 1..7

- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  request pending
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_op` / `req1_op`  in  OP_W  ALU opcode
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes result
- `rsp_data`  out  WIDTH  result, shared; qualified by `rspN_valid`
- `alu_a`, `alu_b`  out  WIDTH  ALU operands
- `alu_op`  out  OP_W  ALU opcode
- `alu_result`  in  WIDTH  ALU output
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `reqN_ready` is asserted combinationally to the arbitration winner only, and only in IDLE.
  - Winner: the only valid requester. If both are valid, the requester indicated by priority pointer `prio` wins.
  - On handshake, latch a/b/op and `owner` into operand registers, load `lat_cnt` = ALU_LAT, set `prio` = other requester, go to EXEC.
- EXEC:
  - `alu_a`/`alu_b`/`alu_op` are driven from the operand registers.
  - `lat_cnt` decrements each cycle.
  - In the cycle `lat_cnt`==0, `alu_result` is captured into `rsp_data`, and the FSM goes to RESP.
  - EXEC lasts ALU_LAT+1 cycles.
- RESP:
  - `rsp<owner>_valid` is held high and `rsp_data` is held stable until `rsp<owner>_ready`.
  - On that handshake, go to IDLE.
  - `rsp_ready` from the non-owner is ignored.
- Outside EXEC, ALU inputs hold their last values. No new request is accepted until the FSM returns to IDLE, so there is at most one operation in flight.
- Opcode and data are passed through unmodified. Width rules belong to the ALU; this block does no arithmetic beyond the counter.

## Timing
- Reset values:
  - outputs: all ready/valid = 0, `busy` = 0, `rsp_data` = 0, `alu_a` = `alu_b` = 0, `alu_op` = 0
  - internal: state = IDLE, `prio` = 0, `lat_cnt` = 0
- Latency:
  - request handshake in cycle T → EXEC in T+1..T+1+ALU_LAT → `rspN_valid` first high in T+2+ALU_LAT
  - With ALU_LAT=1: result valid 3 cycles after accept.
- Throughput: response handshake in cycle R → IDLE in R+1 → earliest next accept in R+1. Minimum issue interval is ALU_LAT+3 cycles.
- Simultaneous valid: grant alternates. With both requesters held valid continuously, grants go 0,1,0,1...
- A requester may drop valid before ready without penalty. `prio` changes only on a grant.
- Backpressure: RESP may last indefinitely, and both `reqN_ready` stay low throughout.
- Reset mid-operation: immediate return to reset values. The in-flight result is discarded, and no `rsp_valid` appears after release.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH`, `OP_W`
  - opcode constants (`OP_ADD`=4'h0, `OP_SUB`=4'h1, ...) shared with `ALU`
  - `arb_state_t` enum {IDLE, EXEC, RESP}
- Sub-module `rr_arb2`: combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: one-hot `gnt[1:0]`.
  - `prio` register stays in `alu_arbiter`.
- Top: FSM, operand/owner registers, `lat_cnt`, result register.

## Test plan
- Single request, ALU_LAT=1:
  - Stimulus: req0 a=1 b=0 op=OP_ADD accepted at cycle 5.
  - Required: `alu_a`=1 in cycles 6–7; `rsp0_valid` high at cycle 8 with `rsp_data`=1; `rsp1_valid` stays 0.
- Contention:
  - Stimulus: req0 and req1 both valid from reset release with `rspN_ready`=1.
  - Required: grants go 0,1,0; req1's first accept comes exactly ALU_LAT+3 cycles after req0's.
- Backpressure:
  - Stimulus: req1 a=0 b=1 op=OP_SUB; `rsp1_ready` held low 10 cycles.
  - Required: `rsp1_valid` and `rsp_data`=16'hFFFF stay stable; `req0_ready`=0 throughout even with req0 valid.
- Reset mid-EXEC:
  - Stimulus: assert `reset_n`=0 during EXEC.
  - Required: `busy`=0 and all valid/ready=0 immediately (asynchronously); no response after release; next req1-only request is granted normally.
- Latency parameter:
  - Stimulus: ALU_LAT=4 build with a bench ALU model delaying 4 cycles; request accepted at T.
  - Required: response at T+6 carries the correct result.
- Withdrawn request:
  - Stimulus: req0 valid for one cycle while FSM is in RESP, then dropped.
  - Required: no grant; `prio` unchanged.
